// File: rtl/bram_burst_loader_pkg.sv
// ---------------------------------------------------------------------------
// bram_burst_loader_pkg
// Shared definitions for the BRAM burst loader slice.
//   PKG_DATA_W  default BRAM word width
//   PKG_ADDR_W  default BRAM address width
//   BRAM_DEPTH  depth of blk_mem_gen_0 (2**PKG_ADDR_W)
//   state_t     loader FSM encoding (IDLE/LOAD/DONE)
// ---------------------------------------------------------------------------
package bram_burst_loader_pkg;

    localparam int unsigned PKG_DATA_W = 32;
    localparam int unsigned PKG_ADDR_W = 3;
    localparam int unsigned BRAM_DEPTH = 2 ** PKG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bram_burst_loader_rca3.sv
// ---------------------------------------------------------------------------
// rca3
// 3-bit ripple-carry adder shared with the window reader's address chain.
//   a, b  in   3  addends
//   cin   in   1  carry in
//   sum   out  3  a + b + cin (mod 8)
//   cout  out  1  carry out
// ---------------------------------------------------------------------------
module rca3
    import bram_burst_loader_pkg::*;
(
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       cout
);

    logic [3:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[3];

endmodule

// File: rtl/bram_burst_loader.sv
// ---------------------------------------------------------------------------
// bram_burst_loader
// Accepts a burst of NUM_WORDS words on a valid/ready stream and writes them
// into the BRAM at consecutive addresses (mod depth) from start_addr, keeping
// an XOR checksum of the burst.
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_addr   begin a burst (IDLE only), first BRAM address
//   abort               terminate the burst, back to IDLE
//   s_valid/s_data      source stream, s_ready = word accepted this cycle
//   bram_ena/wea/addr/din  registered BRAM write port (1-cycle latency)
//   busy                burst in progress (LOAD)
//   done                1-cycle pulse, coincides with the final write strobe
//   checksum            XOR of all words accepted in the last/current burst
// ---------------------------------------------------------------------------
module bram_burst_loader
    import bram_burst_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = PKG_DATA_W,
    parameter int unsigned ADDR_W    = PKG_ADDR_W,
    parameter int unsigned NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W + 1)'(NUM_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W:0]   count;
    logic              beat;

    // abort wins over a simultaneous beat: the word is not taken
    assign s_ready = (state == LOAD) && !abort;
    assign beat    = s_valid && s_ready;
    assign busy    = (state == LOAD);

    // Native 8-deep BRAM reuses the reader's rca3; other depths fall back to +1
    if (2 ** ADDR_W == BRAM_DEPTH) begin : g_rca
        logic addr_cout_unused;
        rca3 u_addr_inc (
            .a    (wr_addr),
            .b    (3'd1),
            .cin  (1'b0),
            .sum  (wr_addr_nxt),
            .cout (addr_cout_unused)
        );
    end else begin : g_add
        assign wr_addr_nxt = wr_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            count     <= '0;
            checksum  <= '0;
            bram_ena  <= 1'b0;
            bram_wea  <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            done      <= 1'b0;
        end else begin
            bram_ena <= 1'b0;
            bram_wea <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= LOAD;
                        wr_addr  <= start_addr;
                        count    <= '0;
                        checksum <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (beat) begin
                        bram_ena  <= 1'b1;
                        bram_wea  <= 1'b1;
                        bram_addr <= wr_addr;
                        bram_din  <= s_data;
                        wr_addr   <= wr_addr_nxt;
                        count     <= count + (ADDR_W + 1)'(1);
                        checksum  <= checksum ^ s_data;
                        // done is raised together with the final write strobe
                        if (count == LAST_BEAT) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_burst_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_burst_loader
// Randomised bench for bram_burst_loader against a transaction-level model:
// a burst is "active", has a base address and an accepted-word count, and
// each accepted word lands at (base + index) mod depth with XOR accumulation.
// ---------------------------------------------------------------------------
module tb_bram_burst_loader;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned NUM_WORDS = 8;
    localparam int unsigned DEPTH     = 8;
    localparam int          GUARD_MAX = 300;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    bram_burst_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_bad;

    // transaction-level model
    bit          m_active;
    bit          m_done;
    bit          m_we;
    int          m_base;
    int          m_n;
    logic [31:0] m_sum;
    logic [2:0]  m_addr;
    logic [31:0] m_din;
    logic [31:0] m_mem [DEPTH];

    // what the DUT actually wrote
    logic [31:0] dut_mem [DEPTH];
    int          obs_writes;
    int          obs_dones;
    int          obs_addrs [$];
    logic [31:0] rand_words [NUM_WORDS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int kind, input int idx);
        case (kind)
            0:       return 32'(idx + 1);
            1:       return 32'(32'hA0 + idx);
            2:       return (idx % 2 == 0) ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default: return rand_words[idx];
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_we     = 0;
        m_base   = 0;
        m_n      = 0;
        m_sum    = '0;
        m_addr   = '0;
        m_din    = '0;
    endtask

    // one clock: drive at negedge, check s_ready, advance model, check outputs after posedge
    task automatic step(input bit st, input logic [2:0] sa, input bit ab, input bit v, input logic [31:0] d);
        bit was_load;
        bit was_done;
        bit rdy;
        bit beat;
        @(negedge clk);
        start      = st;
        start_addr = sa;
        abort      = ab;
        s_valid    = v;
        s_data     = d;
        #1;
        was_load = m_active;
        was_done = m_done;
        rdy      = was_load && !ab;
        check_eq("s_ready", 32'(s_ready), 32'(rdy));
        beat   = rdy && v;
        m_we   = beat;
        m_done = 0;
        if (was_load) begin
            if (ab) begin
                m_active = 0;
            end else if (beat) begin
                m_addr = 3'((m_base + m_n) % DEPTH);
                m_din  = d;
                m_sum  = m_sum ^ d;
                m_mem[m_addr] = d;
                m_n++;
                if (m_n == NUM_WORDS) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (!was_done && st && !ab) begin
            m_active = 1;
            m_base   = int'(sa);
            m_n      = 0;
            m_sum    = '0;
        end
        @(posedge clk);
        #1;
        check_eq("bram_wea", 32'(bram_wea), 32'(m_we));
        check_eq("bram_ena", 32'(bram_ena), 32'(m_we));
        check_eq("bram_addr", 32'(bram_addr), 32'(m_addr));
        check_eq("bram_din", bram_din, m_din);
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("checksum", checksum, m_sum);
        if (bram_wea) begin
            obs_writes++;
            dut_mem[bram_addr] = bram_din;
            obs_addrs.push_back(int'(bram_addr));
        end
        if (done) obs_dones++;
    endtask

    // asynchronous reset between clock edges; outputs must clear before any edge
    task automatic async_reset();
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_wea", 32'(bram_wea), 32'd0);
        check_eq("rst_ena", 32'(bram_ena), 32'd0);
        check_eq("rst_addr", 32'(bram_addr), 32'd0);
        check_eq("rst_din", bram_din, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_checksum", checksum, 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        model_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic burst(input logic [2:0] sa, input int kind, input int vprob,
                         input int abort_at, input int rst_at, input bit spam);
        int          guard;
        bit          v;
        bit          ab;
        bit          st;
        logic [31:0] w;
        obs_writes = 0;
        obs_dones  = 0;
        obs_addrs.delete();
        for (int i = 0; i < NUM_WORDS; i++) rand_words[i] = $urandom;
        step(1'b1, sa, 1'b0, 1'($urandom_range(1)), $urandom);
        guard = 0;
        while ((m_active || m_done) && guard < GUARD_MAX) begin
            guard++;
            if (rst_at >= 0 && m_n == rst_at && m_active) begin
                async_reset();
                break;
            end
            w  = word_of(kind, m_n);
            v  = (kind == 2) ? (guard % 2 == 1) : (int'($urandom_range(99)) < vprob);
            ab = (abort_at >= 0) && (m_n == abort_at) && m_active;
            st = spam && ($urandom_range(2) == 0);
            step(st, 3'($urandom), ab, v, v ? w : $urandom);
        end
        check_eq("burst_in_budget", 32'(guard < GUARD_MAX), 32'd1);
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) check_eq("mem", dut_mem[i], m_mem[i]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 3'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
    endtask

    initial begin
        n_checks   = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        abort      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            dut_mem[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_wea", 32'(bram_wea), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // words 1..8 from address 0, back-to-back
        burst(3'd0, 0, 100, -1, -1, 1'b0);
        check_eq("b1_writes", 32'(obs_writes), 32'd8);
        check_eq("b1_dones", 32'(obs_dones), 32'd1);
        check_eq("b1_checksum", checksum, 32'h8);
        for (int i = 0; i < DEPTH; i++) check_eq("b1_mem", dut_mem[i], 32'(i + 1));
        idle_cycles(3);

        // wrap from address 6
        burst(3'd6, 1, 100, -1, -1, 1'b0);
        check_eq("wrap_writes", 32'(obs_writes), 32'd8);
        for (int i = 0; i < obs_addrs.size(); i++)
            check_eq("wrap_addr", 32'(obs_addrs[i]), 32'((6 + i) % DEPTH));
        check_mem();
        idle_cycles(2);

        // valid toggling
        burst(3'd3, 2, 100, -1, -1, 1'b0);
        check_eq("gap_writes", 32'(obs_writes), 32'd8);
        check_eq("gap_dones", 32'(obs_dones), 32'd1);
        check_eq("gap_checksum", checksum, 32'h0);
        check_mem();

        // abort and start together in IDLE stays idle
        step(1'b1, 3'd5, 1'b1, 1'b1, $urandom);

        // abort after 3 beats
        burst(3'd1, 3, 100, 3, -1, 1'b0);
        check_eq("abort_writes", 32'(obs_writes), 32'd3);
        check_eq("abort_dones", 32'(obs_dones), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_mem();
        idle_cycles(2);

        // start pulses during LOAD are ignored
        burst(3'd2, 3, 70, -1, -1, 1'b1);
        check_eq("spam_writes", 32'(obs_writes), 32'd8);
        for (int i = 0; i < obs_addrs.size(); i++)
            check_eq("spam_addr", 32'(obs_addrs[i]), 32'((2 + i) % DEPTH));
        check_mem();

        // reset mid-burst after 5 beats, then a fresh burst
        burst(3'd4, 3, 100, -1, 5, 1'b0);
        check_eq("rst_writes", 32'(obs_writes), 32'd5);
        check_mem();
        burst(3'd7, 3, 100, -1, -1, 1'b0);
        check_eq("post_rst_writes", 32'(obs_writes), 32'd8);
        check_eq("post_rst_dones", 32'(obs_dones), 32'd1);
        check_mem();

        // random bursts
        for (int b = 0; b < 16; b++) begin
            int ab_at;
            ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(NUM_WORDS - 1)) : -1;
            burst(3'($urandom), 3, int'($urandom_range(100, 30)), ab_at, -1, 1'($urandom_range(1)));
            check_eq("rnd_writes", 32'(obs_writes), (ab_at >= 0) ? 32'(ab_at) : 32'(NUM_WORDS));
            check_eq("rnd_dones", 32'(obs_dones), (ab_at >= 0) ? 32'd0 : 32'd1);
            check_mem();
            idle_cycles(int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
